// File: rtl/servo_frame_gen.sv
// servo_frame_gen
//   Timing and setpoint stage feeding the servo PWM comparator. A prescaler
//   turns clk into a tick at TICK_HZ, a frame counter runs 0..FRAME_TICKS-1 on
//   those ticks, and the pulse-width setpoint y_val is moved toward the latest
//   clamped joystick sample by at most SLEW_STEP per frame, only at frame wrap.
//   If no sample arrives for STALE_FRAMES wraps, the target falls back to centre.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   raw_val      in   [9:0]  unsigned SPI joystick sample
//   raw_valid    in   single-cycle strobe qualifying raw_val
//   cntr_val     out  [14:0] frame tick counter, 0..FRAME_TICKS-1
//   y_val        out  [10:0] pulse-width setpoint in ticks
//   frame_start  out  one-cycle pulse in the first clk cycle of cntr_val == 0
//   sample_stale out  high while the fail-safe target is in force
module servo_frame_gen #(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int TICK_HZ      = 1_000_000,
  parameter int FRAME_TICKS  = 20000,
  parameter int PW_MIN       = 1000,
  parameter int PW_MAX       = 2000,
  parameter int SLEW_STEP    = 50,
  parameter int STALE_FRAMES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  raw_val,
  input  logic        raw_valid,
  output logic [14:0] cntr_val,
  output logic [10:0] y_val,
  output logic        frame_start,
  output logic        sample_stale
);

  localparam int DIV  = CLK_FREQ_HZ / TICK_HZ;
  localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SC_W = $clog2(STALE_FRAMES + 1);

  localparam logic [PS_W-1:0] PS_LAST    = PS_W'(DIV - 1);
  localparam logic [14:0]     FRAME_LAST = 15'(FRAME_TICKS - 1);
  localparam logic [10:0]     PW_LO      = 11'(PW_MIN);
  localparam logic [10:0]     PW_HI      = 11'(PW_MAX);
  localparam logic [10:0]     STEP       = 11'(SLEW_STEP);
  localparam logic [10:0]     CENTER     = 11'((PW_MIN + PW_MAX) / 2);
  localparam logic [SC_W-1:0] STALE_MAX  = SC_W'(STALE_FRAMES);
  localparam logic [SC_W-1:0] STALE_LAST = SC_W'(STALE_FRAMES - 1);

  logic [PS_W-1:0] prescaler;
  logic [10:0]     target;
  logic [SC_W-1:0] stale_cnt;
  logic            tick;
  logic            wrap;
  logic [10:0]     sum;

  // Saturate a pulse width into [PW_MIN, PW_MAX].
  function automatic logic [10:0] clamp_pw(input logic [10:0] s);
    if (s < PW_LO)
      return PW_LO;
    else if (s > PW_HI)
      return PW_HI;
    else
      return s;
  endfunction

  // Move cur toward tgt by at most SLEW_STEP; both operands already lie in
  // [PW_MIN, PW_MAX], so the result cannot leave that range.
  function automatic logic [10:0] slew_pw(input logic [10:0] cur,
                                          input logic [10:0] tgt);
    logic [10:0] diff;
    if (tgt > cur) begin
      diff = tgt - cur;
      return cur + ((diff > STEP) ? STEP : diff);
    end else if (tgt < cur) begin
      diff = cur - tgt;
      return cur - ((diff > STEP) ? STEP : diff);
    end else begin
      return cur;
    end
  endfunction

  assign tick = (prescaler == PS_LAST);
  assign wrap = tick && (cntr_val == FRAME_LAST);
  assign sum  = {1'b0, raw_val} + PW_LO;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler    <= '0;
      cntr_val     <= '0;
      y_val        <= CENTER;
      target       <= CENTER;
      frame_start  <= 1'b0;
      sample_stale <= 1'b0;
      stale_cnt    <= '0;
    end else begin
      // Timebase: prescaler -> tick -> frame counter
      prescaler   <= tick ? '0 : prescaler + 1'b1;
      frame_start <= wrap;
      if (tick)
        cntr_val <= wrap ? '0 : cntr_val + 1'b1;

      // Setpoint update at the frame boundary uses the pre-edge target
      if (wrap)
        y_val <= slew_pw(y_val, target);

      // Sample capture wins over stale accounting on a shared edge
      if (raw_valid) begin
        target       <= clamp_pw(sum);
        stale_cnt    <= '0;
        sample_stale <= 1'b0;
      end else if (wrap && (stale_cnt != STALE_MAX)) begin
        stale_cnt <= stale_cnt + 1'b1;
        if (stale_cnt == STALE_LAST) begin
          sample_stale <= 1'b1;
          target       <= CENTER;
        end
      end
    end
  end

endmodule

// File: tb/tb_servo_frame_gen.sv
// tb_servo_frame_gen
//   Directed bench for servo_frame_gen. A full-rate instance checks the
//   default prescaler timing out of reset; a scaled instance (DIV = 4,
//   FRAME_TICKS = 10, frame = 40 clk) exercises frame timing, slewing,
//   clamping, fail-safe, simultaneous valid/wrap and asynchronous reset.
module tb_servo_frame_gen;

  logic        clk;
  logic        rst;
  logic [9:0]  raw_val;
  logic        raw_valid;
  logic [14:0] cntr_val;
  logic [10:0] y_val;
  logic        frame_start;
  logic        sample_stale;

  logic [14:0] f_cntr_val;
  logic [10:0] f_y_val;
  logic        f_frame_start;
  logic        f_sample_stale;

  int passed;
  int total;

  servo_frame_gen #(
    .CLK_FREQ_HZ (4),
    .TICK_HZ     (1),
    .FRAME_TICKS (10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .raw_val      (raw_val),
    .raw_valid    (raw_valid),
    .cntr_val     (cntr_val),
    .y_val        (y_val),
    .frame_start  (frame_start),
    .sample_stale (sample_stale)
  );

  servo_frame_gen dut_full (
    .clk          (clk),
    .rst          (rst),
    .raw_val      (raw_val),
    .raw_valid    (raw_valid),
    .cntr_val     (f_cntr_val),
    .y_val        (f_y_val),
    .frame_start  (f_frame_start),
    .sample_stale (f_sample_stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [9:0] raw;
    int         exp_y;
    logic       exp_stale;
  } row_t;

  row_t rows[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp)
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    else
      passed++;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the negedge following the next wrap edge, bounded.
  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!frame_start && n < 100);
    check("frame_start_seen", int'(frame_start), 1);
  endtask

  function automatic void add_row(input logic v, input int r, input int y,
                                  input logic s);
    row_t t;
    t.vld = v;
    t.raw = 10'(r);
    t.exp_y = y;
    t.exp_stale = s;
    rows.push_back(t);
  endfunction

  initial begin
    passed    = 0;
    total     = 0;
    raw_val   = '0;
    raw_valid = 1'b0;
    rst       = 1'b1;

    // Row table: one row per frame, optional mid-frame strobe, then the
    // setpoint and stale flag expected right after the closing wrap.
    for (int k = 1; k <= 10; k++) add_row(1'b1, 1023, 1500 + 50 * k, 1'b0);
    add_row(1'b1, 1023, 2000, 1'b0);
    add_row(1'b0, 0, 2000, 1'b0);
    add_row(1'b0, 0, 2000, 1'b0);
    add_row(1'b0, 0, 2000, 1'b0);
    add_row(1'b0, 0, 2000, 1'b1);
    for (int k = 1; k <= 10; k++) add_row(1'b0, 0, 2000 - 50 * k, 1'b1);
    add_row(1'b0, 0, 1500, 1'b1);
    for (int k = 1; k <= 4; k++) add_row(1'b1, 700, 1500 + 50 * k, 1'b0);
    add_row(1'b1, 700, 1700, 1'b0);
    for (int k = 1; k <= 14; k++) add_row(1'b1, 0, 1700 - 50 * k, 1'b0);
    add_row(1'b1, 20, 1020, 1'b0);
    add_row(1'b1, 20, 1020, 1'b0);

    // Reset state
    #12;
    check("rst_cntr", int'(cntr_val), 0);
    check("rst_y", int'(y_val), 1500);
    check("rst_fs", int'(frame_start), 0);
    check("rst_stale", int'(sample_stale), 0);
    check("rst_full_y", int'(f_y_val), 1500);

    // Frame timing out of reset
    @(negedge clk);
    rst = 1'b0;
    step(3);
    check("pre_tick_cntr", int'(cntr_val), 0);
    check("pre_tick_fs", int'(frame_start), 0);
    step(1);
    check("first_tick_cntr", int'(cntr_val), 1);
    step(35);
    check("last_tick_cntr", int'(cntr_val), 9);
    check("last_tick_fs", int'(frame_start), 0);
    step(1);
    check("wrap_cntr", int'(cntr_val), 0);
    check("wrap_fs", int'(frame_start), 1);
    check("wrap_y", int'(y_val), 1500);
    step(1);
    check("fs_one_cycle", int'(frame_start), 0);
    check("post_wrap_cntr", int'(cntr_val), 0);
    step(58);
    check("full_pre_tick", int'(f_cntr_val), 0);
    step(1);
    check("full_first_tick", int'(f_cntr_val), 1);
    check("full_y", int'(f_y_val), 1500);
    check("full_fs", int'(f_frame_start), 0);

    // Simultaneous raw_valid and wrap
    wait_frame();
    step(39);
    check("simul_pre_cntr", int'(cntr_val), 9);
    raw_val   = 10'd1000;
    raw_valid = 1'b1;
    step(1);
    raw_valid = 1'b0;
    check("simul_fs", int'(frame_start), 1);
    check("simul_y_hold", int'(y_val), 1500);
    check("simul_stale", int'(sample_stale), 0);
    // stale_cnt restarted at the shared edge: fail-safe only on the 5th wrap
    for (int i = 0; i < 5; i++) begin
      wait_frame();
      check("simul_y_next", int'(y_val), 1550 + 50 * i);
      check("simul_stale_next", int'(sample_stale), (i == 4) ? 1 : 0);
    end

    // Asynchronous reset mid-frame
    step(13);
    check("pre_arst_cntr", int'(cntr_val), 3);
    check("pre_arst_y", int'(y_val), 1750);
    #2;
    rst = 1'b1;
    #1;
    check("arst_cntr", int'(cntr_val), 0);
    check("arst_y", int'(y_val), 1500);
    check("arst_fs", int'(frame_start), 0);
    check("arst_stale", int'(sample_stale), 0);
    @(negedge clk);
    rst = 1'b0;
    step(3);
    check("arst_pre_tick", int'(cntr_val), 0);
    step(1);
    check("arst_first_tick", int'(cntr_val), 1);
    step(36);
    check("arst_wrap_fs", int'(frame_start), 1);
    check("arst_wrap_cntr", int'(cntr_val), 0);
    check("arst_wrap_y", int'(y_val), 1500);

    // Table-driven frames
    for (int i = 0; i < rows.size(); i++) begin
      step(1);
      check($sformatf("row%0d_fs_low", i), int'(frame_start), 0);
      step(10);
      if (rows[i].vld) begin
        raw_val   = rows[i].raw;
        raw_valid = 1'b1;
        step(1);
        raw_valid = 1'b0;
      end
      wait_frame();
      check($sformatf("row%0d_cntr", i), int'(cntr_val), 0);
      check($sformatf("row%0d_y", i), int'(y_val), rows[i].exp_y);
      check($sformatf("row%0d_stale", i), int'(sample_stale),
            int'(rows[i].exp_stale));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/servo_frame_gen.md
Name: servo_frame_gen

Overview:
Upstream timing and setpoint stage for the servo PWM comparator.
- Generates the 20 ms servo frame as a 1 µs tick counter (cntr_val, 0..19999).
- Converts raw SPI joystick samples into a clamped, slew-limited pulse-width setpoint (y_val, 1000..2000 µs).
- Updates y_val only at frame boundaries, so the downstream comparator never sees a mid-frame change.
- Forces the servo to centre if the SPI link goes silent.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- TICK_HZ, 1_000_000, cntr_val increment rate. DIV = CLK_FREQ_HZ/TICK_HZ = 100.
- FRAME_TICKS, 20000, ticks per PWM frame.
- PW_MIN, 1000, minimum pulse width in ticks.
- PW_MAX, 2000, maximum pulse width in ticks.
- SLEW_STEP, 50, maximum y_val change per frame.
- STALE_FRAMES, 5, number of frames without raw_valid before fail-safe.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- raw_val, in, 10, unsigned SPI joystick sample.
- raw_valid, in, 1, single-cycle strobe qualifying raw_val.
- cntr_val, out, 15, frame tick counter, 0..FRAME_TICKS-1.
- y_val, out, 11, current pulse-width setpoint in ticks.
- frame_start, out, 1, one-cycle pulse in the first clk cycle of cntr_val==0.
- sample_stale, out, 1, high while in fail-safe.

Behaviour:
- Single clock: clk. Reset: rst, asynchronous, active-high.
- Reset values:
  - prescaler = 0, cntr_val = 0.
  - y_val = target = CENTER, where CENTER = (PW_MIN+PW_MAX)/2 = 1500.
  - frame_start = 0, sample_stale = 0, stale_cnt = 0.
  - Reset asserted mid-frame restarts the frame immediately. No partial-state retention.
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - tick = (prescaler == DIV-1).
  - First tick at the 100th rising edge after reset release.
- Frame counter:
  - On tick, cntr_val increments.
  - At FRAME_TICKS-1, wrap = tick AND (cntr_val == FRAME_TICKS-1). On wrap, cntr_val goes to 0.
  - Frame period = DIV*FRAME_TICKS = 2,000,000 clk.
  - frame_start is registered on the wrap edge: high in the first cycle cntr_val == 0, for exactly 1 cycle. It is not asserted out of reset.
- Sample capture:
  - On raw_valid: sum = raw_val + PW_MIN, computed 11-bit (max 2023).
  - target <= clamp(sum, PW_MIN, PW_MAX).
  - stale_cnt <= 0 and sample_stale <= 0.
  - Back-to-back valids: the last one before the wrap edge wins.
- Frame update, on the wrap edge only:
  - If target > y_val: y_val <= y_val + min(SLEW_STEP, target - y_val).
  - If target < y_val: y_val <= y_val - min(SLEW_STEP, y_val - target).
  - Equal: hold.
  - y_val never leaves [PW_MIN, PW_MAX].
- Stale tracking, on the wrap edge without raw_valid:
  - stale_cnt increments, saturating at STALE_FRAMES.
  - When it reaches STALE_FRAMES: sample_stale <= 1 and target <= CENTER.
  - y_val then slews toward CENTER on subsequent frames.
- Simultaneous raw_valid and wrap on the same edge:
  - The slew uses the pre-edge target.
  - The new sample is latched into target and takes effect at the next frame.
  - stale_cnt clears (valid wins over the increment).
  - sample_stale clears.
- y_val and cntr_val are plain registers with no combinational path from inputs. The downstream comparator sees a new y_val coincident with cntr_val == 0.

Test Plan:
- Reset and frame timing: release rst -> cntr_val = 1 after 100 clk; cntr_val = 19999 -> 0 at clk 2,000,000; frame_start high exactly that one cycle; y_val = 1500 throughout.
- Slew up with clamp: raw_val = 1023 strobed mid-frame 0 -> target 2000; y_val = 1550, 1600, … at successive frame starts, reaching 2000 after 10 frames, then holds.
- Slew down and small step: with y_val at 1500, raw_val = 0 -> y_val = 1450 … 1000 over 10 frames; then raw_val = 20 (target 1020) -> y_val = 1020 in one frame.
- Stale fail-safe: y_val = 2000, no raw_valid for 5 wraps -> sample_stale = 1 at the 5th wrap; y_val steps 1950 … 1500 over the next 10 frames. Then raw_valid with raw_val = 700 -> sample_stale = 0; y_val slews 1550 … 1700.
- Simultaneous events: raw_valid (raw_val = 1000) on the same edge as the wrap while target = 1500 and y_val = 1500 -> y_val stays 1500 that frame and becomes 1550 at the next wrap; stale_cnt = 0.
- Async reset mid-operation: assert rst at cntr_val = 12345 with y_val = 1800, without waiting for a clk edge -> all outputs return to reset values immediately; after release, the frame restarts from 0.
